sfx_scheduler: RTL and testbench

Arbitrates one-shot game sound-effect requests (hit, pickup, damage, death) onto the shared APU effect channel. Latches event edges, picks the highest-priority pending effect, and sequences it frame by frame, driving the envelope, tone period, noise enable and background-music duck. Sits between game logic (collision detectors) and the APU mixer. All sequencing advances only on the per-frame tick.

---
 rtl/sfx_scheduler.sv | 200 ++++++++++++++++++++
 tb/tb_sfx_scheduler.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/sfx_scheduler.sv
// Sound-effect scheduler: latches event edges, plays the highest-priority pending effect frame by frame.
// Optional build macro SFX_PREEMPT_EN lets a strictly higher pending effect interrupt the one playing.
module sfx_scheduler #(
    parameter int DUR0       = 16,
    parameter int DUR1       = 24,
    parameter int DUR2       = 32,
    parameter int DUR3       = 48,
    parameter int GAP_FRAMES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic [3:0] evt_req,
    output logic [3:0] evt_ack,
    output logic       sfx_active,
    output logic [1:0] sfx_id,
    output logic [4:0] sfx_env,
    output logic [8:0] tone_period,
    output logic       noise_en,
    output logic       bgm_duck
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  evt_prev;
    logic [3:0]  pending;
    logic [3:0]  rise;
    logic [3:0]  win_mask;
    logic [1:0]  win_id;
    logic        pend_any;
    logic        preempt;
    logic        start;
    logic        last_frame;
    logic        gap_done;
    logic [1:0]  cur_id;
    logic [5:0]  frame_cnt;
    logic [3:0]  gap_cnt;
    logic [4:0]  env_q;
    logic [4:0]  env_nxt;
    logic [8:0]  period_q;
    logic [8:0]  period_nxt;
    logic        noise_q;
    logic [3:0]  ack_q;
    logic signed [10:0] period_sum;

    function automatic logic [8:0] tbl_start(input logic [1:0] id);
        case (id)
            2'd0:    tbl_start = 9'd0;
            2'd1:    tbl_start = 9'd40;
            2'd2:    tbl_start = 9'd120;
            default: tbl_start = 9'd200;
        endcase
    endfunction

    function automatic logic signed [10:0] tbl_step(input logic [1:0] id);
        case (id)
            2'd0:    tbl_step = 11'sd0;
            2'd1:    tbl_step = -11'sd2;
            2'd2:    tbl_step = 11'sd4;
            default: tbl_step = 11'sd3;
        endcase
    endfunction

    function automatic logic [4:0] tbl_decay(input logic [1:0] id);
        case (id)
            2'd0:    tbl_decay = 5'd2;
            2'd1:    tbl_decay = 5'd1;
            2'd2:    tbl_decay = 5'd2;
            default: tbl_decay = 5'd1;
        endcase
    endfunction

    function automatic logic tbl_noise(input logic [1:0] id);
        tbl_noise = (id == 2'd0) || (id == 2'd3);
    endfunction

    function automatic logic [5:0] dur_last(input logic [1:0] id);
        case (id)
            2'd0:    dur_last = 6'(DUR0 - 1);
            2'd1:    dur_last = 6'(DUR1 - 1);
            2'd2:    dur_last = 6'(DUR2 - 1);
            default: dur_last = 6'(DUR3 - 1);
        endcase
    endfunction

    // Arbitration only sees registered pending, so an edge latched on a tick waits for the next tick.
    always_comb begin
        win_id = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (pending[i]) win_id = 2'(i);
        end
    end

    assign pend_any   = |pending;
    assign win_mask   = 4'b0001 << win_id;
    assign rise       = evt_req & ~evt_prev;
    assign last_frame = (frame_cnt == dur_last(cur_id));
    assign gap_done   = (gap_cnt == 4'(GAP_FRAMES - 1));

`ifdef SFX_PREEMPT_EN
    assign preempt = frame_tick && (state == S_PLAY) && pend_any && (win_id > cur_id);
`else
    assign preempt = 1'b0;
`endif

    assign start = (frame_tick && (state == S_IDLE) && pend_any) || preempt;

    // Period math keeps one spare bit above signed 10-bit so a +step near 511 cannot wrap negative.
    assign period_sum = $signed({2'b00, period_q}) + tbl_step(cur_id);

    always_comb begin
        period_nxt = period_sum[8:0];
        if (period_sum < 11'sd0) begin
            period_nxt = 9'd0;
        end else if (period_sum > 11'sd511) begin
            period_nxt = 9'd511;
        end
        env_nxt = (env_q > tbl_decay(cur_id)) ? (env_q - tbl_decay(cur_id)) : 5'd0;
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = S_PLAY;
            S_PLAY: begin
                if (start) begin
                    state_nxt = S_PLAY;
                end else if (frame_tick && last_frame) begin
                    state_nxt = S_GAP;
                end
            end
            S_GAP:   if (frame_tick && gap_done) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            evt_prev  <= 4'd0;
            pending   <= 4'd0;
            ack_q     <= 4'd0;
            cur_id    <= 2'd0;
            frame_cnt <= 6'd0;
            gap_cnt   <= 4'd0;
            env_q     <= 5'd0;
            period_q  <= 9'd0;
            noise_q   <= 1'b0;
        end else begin
            evt_prev <= evt_req;
            // A fresh edge on the bit being consumed this cycle survives: set wins over clear.
            pending  <= (pending & ~(start ? win_mask : 4'd0)) | rise;
            ack_q    <= start ? win_mask : 4'd0;
            if (start) begin
                cur_id    <= win_id;
                frame_cnt <= 6'd0;
                env_q     <= 5'd31;
                period_q  <= tbl_start(win_id);
                noise_q   <= tbl_noise(win_id);
            end else if ((state == S_PLAY) && frame_tick) begin
                if (last_frame) begin
                    env_q    <= 5'd0;
                    period_q <= 9'd0;
                    noise_q  <= 1'b0;
                    gap_cnt  <= 4'd0;
                end else begin
                    env_q     <= env_nxt;
                    period_q  <= period_nxt;
                    frame_cnt <= frame_cnt + 6'd1;
                end
            end else if ((state == S_GAP) && frame_tick) begin
                gap_cnt <= gap_cnt + 4'd1;
            end
        end
    end

    always_comb begin
        evt_ack     = ack_q;
        sfx_active  = (state == S_PLAY);
        sfx_id      = (state == S_PLAY) ? cur_id : 2'd0;
        sfx_env     = env_q;
        tone_period = period_q;
        noise_en    = noise_q;
        bgm_duck    = (state != S_IDLE);
    end

endmodule

// File: tb/tb_sfx_scheduler.sv
// Bench for sfx_scheduler: directed scenarios plus random traffic against a frame-indexed reference model.
module tb_sfx_scheduler;

    localparam int GAP = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       frame_tick;
    logic [3:0] evt_req;
    logic [3:0] evt_ack;
    logic       sfx_active;
    logic [1:0] sfx_id;
    logic [4:0] sfx_env;
    logic [8:0] tone_period;
    logic       noise_en;
    logic       bgm_duck;

    int n_pass  = 0;
    int n_total = 0;
    logic [3:0] exp_q[$];

    // Reference model: phase 0 idle, 1 play, 2 gap; m_k = ticks since the effect started.
    logic [3:0] m_prev, m_pend, m_ack;
    int m_phase, m_id, m_k, m_g;
    logic [3:0] cur_evt;

    sfx_scheduler dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .evt_req(evt_req),
        .evt_ack(evt_ack), .sfx_active(sfx_active), .sfx_id(sfx_id), .sfx_env(sfx_env),
        .tone_period(tone_period), .noise_en(noise_en), .bgm_duck(bgm_duck)
    );

    always #5 clk = ~clk;

    function automatic int dur_of(input int id);
        case (id)
            0: return 16;
            1: return 24;
            2: return 32;
            default: return 48;
        endcase
    endfunction

    function automatic int start_of(input int id);
        case (id)
            0: return 0;
            1: return 40;
            2: return 120;
            default: return 200;
        endcase
    endfunction

    function automatic int step_of(input int id);
        case (id)
            0: return 0;
            1: return -2;
            2: return 4;
            default: return 3;
        endcase
    endfunction

    function automatic int decay_of(input int id);
        return (id == 1 || id == 3) ? 1 : 2;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_start(input int w, inout logic [3:0] pend);
        m_id    = w;
        m_k     = 0;
        m_phase = 1;
        pend[w] = 1'b0;
        m_ack   = 4'(1 << w);
        exp_q.push_back(m_ack);
    endtask

    task automatic model_step(input logic r, input logic [3:0] e, input logic ft);
        logic [3:0] rise;
        logic [3:0] pend;
        int w;
        if (r) begin
            m_prev = 0; m_pend = 0; m_ack = 0;
            m_phase = 0; m_id = 0; m_k = 0; m_g = 0;
            return;
        end
        rise   = e & ~m_prev;
        m_prev = e;
        m_ack  = 0;
        pend   = m_pend;
        w      = -1;
        for (int i = 0; i < 4; i++) if (pend[i]) w = i;
        if (ft) begin
            if (m_phase == 0 && w >= 0) model_start(w, pend);
`ifdef SFX_PREEMPT_EN
            else if (m_phase == 1 && w > m_id) model_start(w, pend);
`endif
            else if (m_phase == 1) begin
                m_k++;
                if (m_k == dur_of(m_id)) begin
                    m_phase = 2;
                    m_g = 0;
                end
            end else if (m_phase == 2) begin
                m_g++;
                if (m_g == GAP) m_phase = 0;
            end
        end
        m_pend = pend | rise;
    endtask

    task automatic check_outputs();
        int e, p;
        logic play;
        play = (m_phase == 1);
        e = 31 - decay_of(m_id) * m_k;
        if (e < 0) e = 0;
        p = start_of(m_id) + step_of(m_id) * m_k;
        if (p < 0) p = 0;
        if (p > 511) p = 511;
        chk("evt_ack", 16'(evt_ack), 16'(m_ack));
        chk("sfx_active", 16'(sfx_active), 16'(play));
        chk("bgm_duck", 16'(bgm_duck), 16'(m_phase != 0));
        chk("sfx_id", 16'(sfx_id), play ? 16'(m_id) : 16'd0);
        chk("sfx_env", 16'(sfx_env), play ? 16'(e) : 16'd0);
        chk("tone_period", 16'(tone_period), play ? 16'(p) : 16'd0);
        chk("noise_en", 16'(noise_en), play ? 16'(m_id == 0 || m_id == 3) : 16'd0);
        if (evt_ack != 4'd0) begin
            if (exp_q.size() == 0) chk("ack_unexpected", 16'(evt_ack), 16'd0);
            else chk("ack_order", 16'(evt_ack), 16'(exp_q.pop_front()));
        end
    endtask

    task automatic cycle(input logic r, input logic [3:0] e, input logic ft);
        rst_n      = r;
        evt_req    = e;
        frame_tick = ft;
        @(posedge clk);
        model_step(r, e, ft);
        #1;
        check_outputs();
        @(negedge clk);
    endtask

    task automatic run_ticks(input int n, input int spacing);
        for (int i = 0; i < n; i++) begin
            cycle(1'b0, cur_evt, 1'b1);
            for (int j = 0; j < spacing; j++) cycle(1'b0, cur_evt, 1'b0);
        end
    endtask

    task automatic pulse(input logic [3:0] bits);
        cur_evt = bits;
        cycle(1'b0, cur_evt, 1'b0);
        cur_evt = 4'd0;
        cycle(1'b0, cur_evt, 1'b0);
    endtask

    initial begin
        cur_evt = 4'd0;
        rst_n = 1'b1; evt_req = 4'd0; frame_tick = 1'b0;
        @(negedge clk);
        repeat (3) cycle(1'b1, 4'd0, 1'b0);
        run_ticks(10, 2);

        pulse(4'b0001);
        run_ticks(22, 2);

        pulse(4'b0010);
        run_ticks(30, 1);

        pulse(4'b0101);
        run_ticks(56, 1);

        pulse(4'b0010);
        run_ticks(3, 1);
        pulse(4'b1000);
        run_ticks(80, 1);

        pulse(4'b0100);
        run_ticks(10, 1);
        pulse(4'b0001);
        run_ticks(2, 1);
        cycle(1'b1, 4'd0, 1'b0);
        run_ticks(6, 1);

        cycle(1'b0, 4'b0010, 1'b1);
        cur_evt = 4'd0;
        run_ticks(30, 1);

        cycle(1'b1, 4'b1000, 1'b0);
        cycle(1'b1, 4'b1000, 1'b0);
        cur_evt = 4'b1000;
        run_ticks(55, 1);
        cur_evt = 4'd0;

        for (int t = 0; t < 400; t++) begin
            int gap_cycles;
            gap_cycles = $urandom_range(0, 3);
            if ($urandom_range(0, 3) == 0) cur_evt ^= 4'($urandom_range(1, 15));
            if (t == 200) cycle(1'b1, cur_evt, 1'b0);
            cycle(1'b0, cur_evt, 1'b1);
            for (int j = 0; j < gap_cycles; j++) begin
                if ($urandom_range(0, 7) == 0) cur_evt ^= 4'($urandom_range(1, 15));
                cycle(1'b0, cur_evt, 1'b0);
            end
        end
        run_ticks(60, 0);

        chk("ack_queue_drained", 16'(exp_q.size()), 16'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
